// File: rtl/input_conditioner.sv
// Front-panel conditioner: 2-flop sync, per-button debounce, edge events, operand load, start/mode control.
// Optional INPUT_COND_START_QUEUE_EN holds one busy-blocked start request until busy drops.
module input_conditioner #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_MODES       = 2,
  localparam int MODE_W         = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] switches,
  input  logic              btn_load_x,
  input  logic              btn_load_y,
  input  logic              btn_start,
  input  logic              btn_mode,
  input  logic              busy,
  output logic [DATA_W-1:0] x_input,
  output logic [DATA_W-1:0] y_input,
  output logic              x_valid,
  output logic              y_valid,
  output logic              start,
  output logic              start_dropped,
  output logic [MODE_W-1:0] mode,
  output logic              K_mode
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NB    = 4;

  // Button bit order: 0 load_x, 1 load_y, 2 start, 3 mode
  logic [NB-1:0]     w_btn_raw;
  logic [NB-1:0]     r_btn_s1, r_btn_s2;
  logic [DATA_W-1:0] r_sw_s1, r_sw_s2;
  logic [NB-1:0]     r_db, r_db_d, r_evt;
  logic [CNT_W-1:0]  r_cnt [NB];

  logic [DATA_W-1:0] r_x, r_y;
  logic              r_xv, r_yv, r_start, r_drop, r_pend;
  logic [MODE_W-1:0] r_mode;

  logic              w_ops_ok, w_start_n, w_drop_n, w_pend_n;

  assign w_btn_raw = {btn_mode, btn_start, btn_load_y, btn_load_x};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db   <= '0;
      r_db_d <= '0;
      r_evt  <= '0;
      for (int unsigned i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_db_d <= r_db;
      r_evt  <= r_db & ~r_db_d;
      for (int unsigned i = 0; i < NB; i++) begin
        if (r_btn_s2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_btn_s2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Valid flags are the pre-load values, so a same-cycle load cannot enable start.
  assign w_ops_ok = r_xv && r_yv;

  always_comb begin
    w_start_n = 1'b0;
    w_drop_n  = 1'b0;
    w_pend_n  = 1'b0;
`ifdef INPUT_COND_START_QUEUE_EN
    w_pend_n = r_pend;
    if (r_pend) begin
      if (!busy) begin
        w_start_n = 1'b1;
        w_pend_n  = 1'b0;
      end
      if (r_evt[2]) w_drop_n = 1'b1;
    end else if (r_evt[2]) begin
      if (w_ops_ok && !busy) w_start_n = 1'b1;
      else if (w_ops_ok)     w_pend_n  = 1'b1;
      else                   w_drop_n  = 1'b1;
    end
`else
    if (r_evt[2]) begin
      if (w_ops_ok && !busy) w_start_n = 1'b1;
      else                   w_drop_n  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xv    <= 1'b0;
      r_yv    <= 1'b0;
      r_start <= 1'b0;
      r_drop  <= 1'b0;
      r_pend  <= 1'b0;
      r_mode  <= '0;
    end else begin
      if (r_evt[0]) begin
        r_x  <= r_sw_s2;
        r_xv <= 1'b1;
      end
      if (r_evt[1]) begin
        r_y  <= r_sw_s2;
        r_yv <= 1'b1;
      end
      r_start <= w_start_n;
      r_drop  <= w_drop_n;
      r_pend  <= w_pend_n;
      if (r_evt[3] && !busy)
        r_mode <= (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + 1'b1;
    end
  end

  assign x_input       = r_x;
  assign y_input       = r_y;
  assign x_valid       = r_xv;
  assign y_valid       = r_yv;
  assign start         = r_start;
  assign start_dropped = r_drop;
  assign mode          = r_mode;
  assign K_mode        = (r_mode == MODE_W'(1));

endmodule
